// File: rtl/aes128_iter_multilane_pkg.sv
// Shared AES-128 constants, types and GF(2^8) helpers for the iterative multilane core.
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {IDLE, KEXP, RUN, DONE} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes128_iter_multilane_if.sv
// Key, input and output handshake bundle of the multilane AES core.
interface aes128_iter_multilane_if
    import aes_pkg::*;
#(
    parameter int LANES = 4
);
    localparam int W = 128 * LANES;

    logic         key_valid;
    logic         key_ready;
    block_t       key_in;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    modport master (
        output key_valid, key_in, in_valid, in_mode, in_data, out_ready,
        input  key_ready, in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  key_valid, key_in, in_valid, in_mode, in_data, out_ready,
        output key_ready, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes128_iter_multilane_round_lane.sv
// One combinational AES-128 round on a single 128-bit lane, encrypt or decrypt.
module aes128_round_lane
    import aes_pkg::*;
(
    input  block_t state,
    input  block_t round_key,
    input  logic   mode,
    input  logic   last,
    output block_t next_state
);

    // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
    function automatic block_t enc_round(block_t s, block_t k, logic fin);
        block_t     sr;
        block_t     mc;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(r+4*c) -: 8] = SBOX[s[127-8*(r+4*((c+r)%4)) -: 8]];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            mc[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return (fin ? sr : mc) ^ k;
    endfunction

    function automatic block_t dec_round(block_t s, block_t k, logic fin);
        block_t     t;
        block_t     mc;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(r+4*c) -: 8] = INV_SBOX[s[127-8*(r+4*((c+4-r)%4)) -: 8]];
            end
        end
        t = t ^ k;
        for (int c = 0; c < 4; c++) begin
            a0 = t[127-32*c -: 8];
            a1 = t[119-32*c -: 8];
            a2 = t[111-32*c -: 8];
            a3 = t[103-32*c -: 8];
            mc[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            mc[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            mc[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            mc[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return fin ? t : mc;
    endfunction

    always_comb begin
        next_state = mode ? dec_round(state, round_key, last)
                          : enc_round(state, round_key, last);
    end

endmodule

// File: rtl/aes128_iter_multilane.sv
// Iterative AES-128 over LANES parallel blocks: one-time key expansion, then one round per clock.
module aes128_iter_multilane
    import aes_pkg::*;
#(
    parameter int LANES = 4,
    parameter int NR    = 10
)
(
    input logic clk,
    input logic rst_n,
    aes128_iter_multilane_if.slave bus
);

    localparam int         W    = 128 * LANES;
    localparam logic [3:0] LAST = 4'(NR);

    if (NR != 10) begin : g_nr_check
        $error("aes128_iter_multilane: NR must be 10 for AES-128");
    end

    state_t       st;
    logic         keys_ok;
    logic [3:0]   round;
    block_t       rk [11];
    logic         mode_r;
    logic [W-1:0] data_r;
    logic [W-1:0] lane_next;
    logic [W-1:0] out_data_r;
    logic         out_valid_r;
    block_t       rk_sel;

    function automatic block_t key_step(block_t prev, logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {SBOX[prev[23:16]], SBOX[prev[15:8]], SBOX[prev[7:0]], SBOX[prev[31:24]]}
             ^ {rc, 24'h000000};
        n0 = prev[127:96] ^ t;
        n1 = prev[95:64]  ^ n0;
        n2 = prev[63:32]  ^ n1;
        n3 = prev[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Decrypt walks the schedule backwards from rk[10].
    assign rk_sel = mode_r ? rk[LAST - round] : rk[round];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes128_round_lane u_lane (
            .state      (data_r[W-1-128*g -: 128]),
            .round_key  (rk_sel),
            .mode       (mode_r),
            .last       (round == LAST),
            .next_state (lane_next[W-1-128*g -: 128])
        );
    end

    assign bus.key_ready = (st == IDLE);
    assign bus.in_ready  = (st == IDLE) && keys_ok && !bus.key_valid;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.busy      = (st != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            keys_ok     <= 1'b0;
            round       <= 4'd0;
            mode_r      <= 1'b0;
            data_r      <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.key_valid) begin
                        rk[0]   <= bus.key_in;
                        keys_ok <= 1'b0;
                        round   <= 4'd1;
                        st      <= KEXP;
                    end else if (bus.in_valid && keys_ok) begin
                        mode_r <= bus.in_mode;
                        data_r <= bus.in_data ^ {LANES{bus.in_mode ? rk[10] : rk[0]}};
                        round  <= 4'd1;
                        st     <= RUN;
                    end
                end
                KEXP: begin
                    rk[round] <= key_step(rk[round - 4'd1], RCON[round]);
                    if (round == LAST) begin
                        keys_ok <= 1'b1;
                        round   <= 4'd0;
                        st      <= IDLE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                RUN: begin
                    data_r <= lane_next;
                    if (round == LAST) begin
                        out_data_r  <= lane_next;
                        out_valid_r <= 1'b1;
                        round       <= 4'd0;
                        st          <= DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        st          <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_iter_multilane.sv
// Randomised and known-answer checks of aes128_iter_multilane against a textbook AES model.
module tb_aes128_iter_multilane;

    localparam int LANES = 4;
    localparam int W     = 128 * LANES;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    aes128_iter_multilane_if #(.LANES(LANES)) bus ();

    aes128_iter_multilane #(.LANES(LANES), .NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: S-boxes derived from GF(2^8) inversion plus the affine map.
    logic [7:0]   m_sbox  [256];
    logic [7:0]   m_isbox [256];
    logic [127:0] m_rk    [11];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            m_sbox[x]  = s;
            m_isbox[s] = 8'(x);
        end
    endfunction

    function automatic void model_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]], m_sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        int row, col, src;
        for (int i = 0; i < 16; i++) begin
            row = i % 4;
            col = i / 4;
            src = inv ? row + 4 * ((col + 4 - row) % 4) : row + 4 * ((col + row) % 4);
            y[127-8*i -: 8] = inv ? m_isbox[x[127-8*src -: 8]] : m_sbox[x[127-8*src -: 8]];
        end
        return y;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] x, input logic inv);
        logic [7:0]   coef [4];
        logic [127:0] y;
        logic [7:0]   acc;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[(j - r + 4) % 4], x[127-8*(4*c+j) -: 8]);
                y[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] model_cipher(input logic dec, input logic [127:0] blk);
        logic [127:0] s;
        logic [127:0] t;
        s = blk ^ (dec ? m_rk[10] : m_rk[0]);
        for (int r = 1; r <= 10; r++) begin
            t = sub_shift(s, dec);
            if (!dec) begin
                if (r < 10) t = mix(t, 1'b0);
                s = t ^ m_rk[r];
            end else begin
                s = t ^ m_rk[10-r];
                if (r < 10) s = mix(s, 1'b1);
            end
        end
        return s;
    endfunction

    function automatic logic [W-1:0] model_txn(input logic dec, input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int l = 0; l < LANES; l++) r[W-1-128*l -: 128] = model_cipher(dec, d[W-1-128*l -: 128]);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int j = 0; j < W / 32; j++) d[32*j +: 32] = $urandom;
        return d;
    endfunction

    task automatic load_key(input logic [127:0] k, output int low_cycles);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_in    = k;
        while (!bus.key_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("key_accept_timeout", W'(guard), W'(0));
        @(posedge clk);
        @(negedge clk);
        bus.key_valid = 1'b0;
        model_key(k);
        low_cycles = 0;
        while (!bus.key_ready && low_cycles < 50) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic offer(input logic mode, input logic [W-1:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_data  = d;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("in_accept_timeout", W'(guard), W'(0));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Entered on the falling edge just after the accept edge.
    task automatic collect(input int hold, output logic [W-1:0] res, output int lat, output logic rules_ok);
        lat      = 0;
        rules_ok = 1'b1;
        while (!bus.out_valid && lat < 50) begin
            if (bus.key_ready || bus.in_ready || !bus.busy) rules_ok = 1'b0;
            lat++;
            @(negedge clk);
        end
        res = bus.out_data;
        for (int i = 0; i < hold; i++) begin
            if (bus.out_data !== res || bus.in_ready || bus.key_ready || !bus.busy || !bus.out_valid)
                rules_ok = 1'b0;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("drain_idle", W'({bus.busy, bus.out_valid}), W'(2'b00));
        check("out_data_kept", bus.out_data, res);
    endtask

    initial begin
        logic [W-1:0] d, res, pt;
        int           lat, low;
        logic         ok;
        logic [127:0] k;

        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        pt            = '0;
        build_sbox();

        repeat (3) @(negedge clk);
        check("reset_outputs", W'({bus.busy, bus.out_valid, bus.in_ready, bus.key_ready}), W'(4'b0001));
        check("reset_out_data", bus.out_data, '0);
        rst_n = 1'b1;

        load_key(K_C1, low);
        check("c1_kexp_cycles", W'(low), W'(10));
        check("c1_in_ready", W'(bus.in_ready), W'(1));
        d = {LANES{PT_C1}};
        offer(1'b0, d);
        collect(0, res, lat, ok);
        check("c1_encrypt", res, {LANES{CT_C1}});
        check("c1_latency", W'(lat), W'(10));
        check("c1_ready_rules", W'(ok), W'(1));

        load_key(K_B, low);
        d = {PT_B, {(W-128){1'b0}}};
        offer(1'b0, d);
        collect(0, res, lat, ok);
        check("appb_lane0", W'(res[W-1 -: 128]), W'(CT_B));
        check("appb_all_lanes", res, model_txn(1'b0, d));

        load_key(K_C1, low);
        offer(1'b1, {LANES{CT_C1}});
        collect(0, res, lat, ok);
        check("c1_decrypt", res, {LANES{PT_C1}});
        check("c1_dec_latency", W'(lat), W'(10));

        k = {$urandom, $urandom, $urandom, $urandom};
        load_key(k, low);
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0) begin
                d  = rand_data();
                pt = d;
            end else begin
                d = res;
            end
            offer(1'(n % 2), d);
            collect(0, res, lat, ok);
            check($sformatf("rand_txn%0d", n), res, model_txn(1'(n % 2), d));
            if (n % 2 == 1) check($sformatf("round_trip%0d", n), res, pt);
        end

        d = rand_data();
        offer(1'b0, d);
        collect(20, res, lat, ok);
        check("bp_stable", W'(ok), W'(1));
        check("bp_result", res, model_txn(1'b0, d));

        k = {$urandom, $urandom, $urandom, $urandom};
        d = rand_data();
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_in    = k;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_data   = d;
        #1;
        check("cont_ready_pair", W'({bus.key_ready, bus.in_ready}), W'(2'b10));
        @(posedge clk);
        @(negedge clk);
        bus.key_valid = 1'b0;
        model_key(k);
        check("cont_busy", W'(bus.busy), W'(1));
        low = 0;
        while (!bus.in_ready && low < 50) begin
            low++;
            @(negedge clk);
        end
        check("cont_wait", W'(low), W'(10));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        collect(0, res, lat, ok);
        check("cont_new_key", res, model_txn(1'b0, d));

        d = rand_data();
        offer(1'b1, d);
        k = {$urandom, $urandom, $urandom, $urandom};
        bus.key_valid = 1'b1;
        bus.key_in    = k;
        collect(0, res, lat, ok);
        check("run_key_blocked", W'(ok), W'(1));
        check("run_old_key", res, model_txn(1'b1, d));
        check("run_key_ready_idle", W'(bus.key_ready), W'(1));
        @(posedge clk);
        @(negedge clk);
        bus.key_valid = 1'b0;
        model_key(k);
        check("run_key_taken", W'({bus.busy, bus.key_ready}), W'(2'b10));
        low = 0;
        while (!bus.key_ready && low < 50) begin
            low++;
            @(negedge clk);
        end
        d = rand_data();
        offer(1'b0, d);
        collect(0, res, lat, ok);
        check("run_key_applied", res, model_txn(1'b0, d));

        d = rand_data();
        offer(1'b0, d);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", W'({bus.busy, bus.out_valid, bus.in_ready, bus.key_ready}), W'(4'b0001));
        check("rst_mid_out_data", bus.out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_keys_lost", W'({bus.in_ready, bus.key_ready}), W'(2'b01));
        load_key(K_C1, low);
        offer(1'b0, {LANES{PT_C1}});
        collect(0, res, lat, ok);
        check("rst_reload_encrypt", res, {LANES{CT_C1}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
